// File: rtl/wdpm_pkg.sv
// rtl/wdpm_pkg.sv - shared write-back destination codes and result demux FSM states
package wdpm_pkg;

  typedef enum logic [1:0] {
    DST_RF   = 2'b00,
    DST_ID   = 2'b01,
    DST_DISC = 2'b10,
    DST_DM   = 2'b11
  } dst_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RF_WR   = 2'b01,
    ST_DM_WAIT = 2'b10
  } demux_state_e;

  // ID is a source-only code; it can never be a write-back target.
  function automatic logic dst_is_illegal(input logic [1:0] code);
    return code == DST_ID;
  endfunction

endpackage

// File: rtl/result_demux.sv
// rtl/result_demux.sv - routes ALU results to the register file or data memory
module result_demux
  import wdpm_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [1:0]        dst,
  input  logic [7:0]        addr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rf_we,
  output logic [2:0]        rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              dm_req,
  output logic [7:0]        dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  output logic              err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  demux_state_e      state_q, state_d;
  logic [7:0]        addr_q;
  logic [DATA_W-1:0] data_q;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q <= addr;
        data_q <= alu_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dst_is_illegal(dst)) begin
            err_d = 1'b1;
          end else if (dst == DST_RF) begin
            state_d = ST_RF_WR;
          end else if (dst == DST_DM) begin
            state_d = ST_DM_WAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_RF_WR: begin
        state_d = ST_IDLE;
      end
      ST_DM_WAIT: begin
        // An acknowledge in the final allowed cycle still completes the write.
        if (dm_ack) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready = (state_q == ST_IDLE);
  assign rf_we    = (state_q == ST_RF_WR);
  assign dm_req   = (state_q == ST_DM_WAIT);
  assign rf_addr  = addr_q[2:0];
  assign rf_wdata = data_q;
  assign dm_addr  = addr_q;
  assign dm_wdata = data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_result_demux.sv
// tb/tb_result_demux.sv - table-driven bench for result_demux
module tb_result_demux;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] alu_data = '0;
  logic [1:0] dst = '0;
  logic [7:0] addr = '0;
  logic       in_valid = 1'b0;
  logic       dm_ack = 1'b0;
  logic       in_ready, rf_we, dm_req, err;
  logic [2:0] rf_addr;
  logic [7:0] rf_wdata, dm_addr, dm_wdata;

  logic [7:0] alu_data1 = '0;
  logic [1:0] dst1 = '0;
  logic [7:0] addr1 = '0;
  logic       in_valid1 = 1'b0;
  logic       dm_ack1 = 1'b0;
  logic       in_ready1, rf_we1, dm_req1, err1;
  logic [2:0] rf_addr1;
  logic [7:0] rf_wdata1, dm_addr1, dm_wdata1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  result_demux #(.DATA_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .alu_data(alu_data), .dst(dst), .addr(addr),
    .in_valid(in_valid), .in_ready(in_ready), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .err(err)
  );

  result_demux #(.DATA_W(8), .TIMEOUT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .alu_data(alu_data1), .dst(dst1), .addr(addr1),
    .in_valid(in_valid1), .in_ready(in_ready1), .rf_we(rf_we1), .rf_addr(rf_addr1),
    .rf_wdata(rf_wdata1), .dm_req(dm_req1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_ack(dm_ack1), .err(err1)
  );

  typedef struct {
    logic [1:0] dst;
    logic [7:0] addr;
    logic [7:0] data;
    int         ack_at;
    int         exp_rf;
    int         exp_dm;
    logic       exp_err;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  rf_n = 0;
    int  dm_n = 0;
    int  bad = 0;
    bit  done = 0;
    @(negedge clk);
    chk($sformatf("v%0d_ready_pre", idx), {31'd0, in_ready}, 32'd1);
    dst = v.dst; addr = v.addr; alu_data = v.data; in_valid = 1'b1; dm_ack = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (rf_we) begin
        rf_n++;
        if (rf_addr !== v.addr[2:0] || rf_wdata !== v.data || in_ready !== 1'b0) bad++;
      end
      if (dm_req) begin
        dm_n++;
        if (dm_addr !== v.addr || dm_wdata !== v.data || in_ready !== 1'b0) bad++;
        dm_ack = (dm_n == v.ack_at);
      end else begin
        dm_ack = 1'b0;
      end
      if (in_ready) done = 1;
    end
    dm_ack = 1'b0;
    chk($sformatf("v%0d_back_to_idle", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d_rf_we_cycles", idx), rf_n, v.exp_rf);
    chk($sformatf("v%0d_dm_req_cycles", idx), dm_n, v.exp_dm);
    chk($sformatf("v%0d_addr_data_stable", idx), bad, 0);
    chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, v.exp_err});
  endtask

  initial begin
    int bad;

    tbl[0] = '{2'b00, 8'h05, 8'hA5, 0, 1, 0, 1'b0};
    tbl[1] = '{2'b11, 8'h40, 8'h3C, 3, 0, 3, 1'b0};
    tbl[2] = '{2'b00, 8'hFF, 8'h5A, 0, 1, 0, 1'b0};
    tbl[3] = '{2'b11, 8'hC3, 8'h81, 1, 0, 1, 1'b0};
    tbl[4] = '{2'b10, 8'h12, 8'h34, 0, 0, 0, 1'b0};
    tbl[5] = '{2'b11, 8'h7E, 8'hE7, 15, 0, 15, 1'b0};
    tbl[6] = '{2'b11, 8'h21, 8'h66, 0, 0, 15, 1'b1};
    tbl[7] = '{2'b00, 8'h0B, 8'h99, 0, 1, 0, 1'b1};
    tbl[8] = '{2'b10, 8'h01, 8'h02, 0, 0, 0, 1'b1};

    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dm_addr", {24'd0, dm_addr}, 32'd0);
    chk("rst_rf_wdata", {24'd0, rf_wdata}, 32'd0);
    do_reset();

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

    // illegal then discard back-to-back
    do_reset();
    @(negedge clk);
    chk("bb_err_pre", {31'd0, err}, 32'd0);
    dst = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    chk("bb_err_after_id", {31'd0, err}, 32'd1);
    chk("bb_ready_1", {31'd0, in_ready}, 32'd1);
    dst = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bb_ready_2", {31'd0, in_ready}, 32'd1);
    chk("bb_no_strobe", {30'd0, rf_we, dm_req}, 32'd0);
    chk("bb_err_sticky", {31'd0, err}, 32'd1);

    // reset during DM_WAIT, then a late acknowledge
    @(negedge clk);
    dst = 2'b11; addr = 8'h77; alu_data = 8'h99; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_dm_req_pre", {31'd0, dm_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("mid_rst_err", {31'd0, err}, 32'd0);
    chk("mid_rst_dm_addr", {24'd0, dm_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dm_ack = 1'b1;
    #1;
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (dm_req || rf_we || !in_ready || err) bad++;
    end
    dm_ack = 1'b0;
    chk("late_ack_ignored", bad, 0);

    // TIMEOUT=1 instance: ack on the only request cycle, then no ack
    @(negedge clk);
    dst1 = 2'b11; addr1 = 8'hAA; alu_data1 = 8'h55; in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    chk("t1_req", {31'd0, dm_req1}, 32'd1);
    chk("t1_req_data", {dm_addr1, dm_wdata1}, 32'h0000AA55);
    dm_ack1 = 1'b1;
    @(negedge clk);
    dm_ack1 = 1'b0;
    chk("t1_req_single", {31'd0, dm_req1}, 32'd0);
    chk("t1_ack_wins", {31'd0, err1}, 32'd0);
    chk("t1_ready", {31'd0, in_ready1}, 32'd1);
    in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    @(negedge clk);
    chk("t1_req2", {31'd0, dm_req1}, 32'd1);
    @(negedge clk);
    chk("t1_req2_dropped", {31'd0, dm_req1}, 32'd0);
    chk("t1_timeout_err", {31'd0, err1}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/result_demux.md
RESULT_DEMUX -- requirements
Module: result_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath width of result, RF and DM data.
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles DM_REQ is held waiting for DM_ACK; legal range 1..255.
REQ-003 SHALL have clock and reset ports exactly as decided: one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  single rising-edge clock.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 ALU_DATA  input  DATA_W  ALU result to be written back.
REQ-007 DST  input  2  destination code: 00 RF, 11 DM, 10 discard, 01 illegal (ID is source-only).
REQ-008 ADDR  input  8  destination address; RF uses ADDR[2:0], DM uses all 8 bits.
REQ-009 IN_VALID  input  1  result valid; IN_READY  output  1  block can accept.
REQ-010 RF_WE  output  1  RF write strobe; RF_ADDR  output  3; RF_WDATA  output  DATA_W.
REQ-011 DM_REQ  output  1  DM write request; DM_ADDR  output  8; DM_WDATA  output  DATA_W; DM_ACK  input  1.
REQ-012 ERR  output  1  sticky error flag (illegal DST or DM timeout).

Function
REQ-013 SHALL accept a transfer on a rising edge where IN_VALID=1 and IN_READY=1, registering ALU_DATA, DST, ADDR.
REQ-014 SHALL implement FSM states IDLE, RF_WR, DM_WAIT; IN_READY=1 only in IDLE (combinational from state).
REQ-015 IDLE: accept with DST=00 -> RF_WR; DST=11 -> DM_WAIT; DST=10 -> stay IDLE, no write; DST=01 -> stay IDLE, set ERR, no write.
REQ-016 RF_WR: RF_WE=1 for exactly one cycle (cycle after acceptance) with registered address/data; next state IDLE.
REQ-017 DM_WAIT: DM_REQ=1 with DM_ADDR/DM_WDATA stable from cycle after acceptance until DM_ACK sampled 1; DM_ACK=1 on the first DM_REQ cycle completes the write in that cycle.
REQ-018 On DM_ACK=1 in DM_WAIT: next state IDLE, DM_REQ deasserted next cycle.
REQ-019 SHALL count DM_WAIT cycles with an 8-bit counter cleared on DM_WAIT entry; after TIMEOUT cycles without DM_ACK, drop request, set ERR, return to IDLE.
REQ-020 DM_ACK and timeout in the same cycle: ACK wins, ERR not set.
REQ-021 DM_ACK outside DM_WAIT SHALL be ignored.
REQ-022 Throughput: one RF result per 2 cycles; DM results limited by DM_ACK latency.
REQ-023 ERR SHALL remain 1 until reset; it does not block further transfers.
REQ-024 RF_WDATA/DM_WDATA/addresses SHALL hold the last registered values when strobes are low.

Reset
REQ-025 RST_N=0 SHALL asynchronously force state IDLE, RF_WE=0, DM_REQ=0, ERR=0, all address/data registers and counter to 0.
REQ-026 Reset mid-DM_WAIT or mid-RF_WR SHALL abandon the pending write; no strobe after reset release until a new acceptance.
REQ-027 IN_READY SHALL be 1 in the first cycle after reset release.

Structure
REQ-028 The 2-bit destination codes (RF=00, ID=01, DM=11) and FSM state enum SHALL live in shared package wdpm_pkg, also used by the ALU operand mux.
REQ-029 Single module; no sub-module required (timeout counter inline).

Verification
REQ-030 Reset, then ALU_DATA=8'hA5, DST=00, ADDR=8'h05, IN_VALID for 1 cycle -> RF_WE=1 one cycle later, RF_ADDR=5, RF_WDATA=A5; IN_READY=0 that cycle.
REQ-031 DST=11, ADDR=8'h40, data 8'h3C, DM_ACK after 3 cycles -> DM_REQ high exactly 3 cycles with stable 40/3C, IN_READY back to 1 next cycle, ERR=0.
REQ-032 DST=11, DM_ACK never -> DM_REQ drops after 15 cycles, ERR=1 and stays 1 through following RF write.
REQ-033 DST=01 and DST=10 back-to-back -> no RF_WE/DM_REQ; ERR=1 after first only; IN_READY stays 1.
REQ-034 RST_N low during DM_WAIT (cycle 2) -> DM_REQ=0 immediately, ERR=0; late DM_ACK after release ignored.
REQ-035 DM_ACK=1 on first DM_REQ cycle -> single-cycle DM_REQ; TIMEOUT=1 with same-cycle ACK -> ERR=0.
